// File: rtl/rtc_alarm_core.sv
// Real-time clock with BCD time, a single daily alarm and a button-driven edit mode.
// Time only counts in RUN and the alarm-edit modes; editing the clock freezes it.
module rtc_alarm_core #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int ALARM_SEC = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] buttonState,
  output logic [3:0] h1,
  output logic [3:0] h0,
  output logic [3:0] m1,
  output logic [3:0] m0,
  output logic [3:0] s1,
  output logic [3:0] s0,
  output logic [3:0] ah1,
  output logic [3:0] ah0,
  output logic [3:0] am1,
  output logic [3:0] am0,
  output logic [2:0] mode,
  output logic       alarm_en,
  output logic       alarm_active,
  output logic       tick
);

  localparam int                 DIV_W     = $clog2(CLK_HZ);
  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(CLK_HZ - 1);
  localparam logic [7:0]         RING_LAST = 8'(ALARM_SEC - 1);
  localparam logic [1:0]         BTN_SHORT = 2'd1;
  localparam logic [1:0]         BTN_LONG  = 2'd2;

  typedef enum logic [2:0] {
    RUN           = 3'd0,
    EDIT_MIN      = 3'd1,
    EDIT_HOUR     = 3'd2,
    EDIT_ALM_MIN  = 3'd3,
    EDIT_ALM_HOUR = 3'd4
  } mode_e;

  mode_e            mode_q, mode_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       hour_q, hour_d, min_q, min_d, sec_q, sec_d;
  logic [7:0]       ahour_q, ahour_d, amin_q, amin_d;
  logic [7:0]       ring_q, ring_d;
  logic             alarm_en_q, alarm_en_d;
  logic             alarm_active_q, alarm_active_d;
  logic             short_press, long_press, running, tick_w, alarm_hit;

  // Two-digit BCD increments; both values are kept as {tens, units}.
  function automatic logic [7:0] inc60(input logic [7:0] v);
    if (v[3:0] == 4'd9) inc60 = (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
    else                inc60 = {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] inc24(input logic [7:0] v);
    if (v == 8'h23)          inc24 = 8'h00;
    else if (v[3:0] == 4'd9) inc24 = {v[7:4] + 4'd1, 4'd0};
    else                     inc24 = {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign short_press = (buttonState == BTN_SHORT);
  assign long_press  = (buttonState == BTN_LONG);
  assign running     = (mode_q == RUN) || (mode_q == EDIT_ALM_MIN) || (mode_q == EDIT_ALM_HOUR);
  assign tick_w      = running && (div_q == DIV_LAST);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mode_q <= RUN;
    else        mode_q <= mode_d;
  end

  // Next-state logic: a long press in RUN while ringing only silences the alarm.
  always_comb begin
    mode_d = mode_q;
    if (long_press && !(mode_q == RUN && alarm_active_q)) begin
      case (mode_q)
        RUN:          mode_d = EDIT_MIN;
        EDIT_MIN:     mode_d = EDIT_HOUR;
        EDIT_HOUR:    mode_d = EDIT_ALM_MIN;
        EDIT_ALM_MIN: mode_d = EDIT_ALM_HOUR;
        default:      mode_d = RUN;
      endcase
    end
  end

  // Output logic.
  always_comb begin
    mode         = mode_q;
    tick         = tick_w;
    alarm_en     = alarm_en_q;
    alarm_active = alarm_active_q;
    {h1, h0}     = hour_q;
    {m1, m0}     = min_q;
    {s1, s0}     = sec_q;
    {ah1, ah0}   = ahour_q;
    {am1, am0}   = amin_q;
  end

  always_comb begin
    div_d          = running ? (tick_w ? '0 : div_q + 1'b1) : '0;
    hour_d         = hour_q;
    min_d          = min_q;
    sec_d          = sec_q;
    ahour_d        = ahour_q;
    amin_d         = amin_q;
    alarm_en_d     = alarm_en_q;
    alarm_active_d = alarm_active_q;
    ring_d         = ring_q;

    if (tick_w) begin
      sec_d = inc60(sec_q);
      if (sec_q == 8'h59) begin
        min_d = inc60(min_q);
        if (min_q == 8'h59) hour_d = inc24(hour_q);
      end
    end

    if (short_press) begin
      case (mode_q)
        EDIT_MIN:      begin min_d  = inc60(min_q);  sec_d = 8'h00; end
        EDIT_HOUR:     begin hour_d = inc24(hour_q); sec_d = 8'h00; end
        EDIT_ALM_MIN:  amin_d  = inc60(amin_q);
        EDIT_ALM_HOUR: ahour_d = inc24(ahour_q);
        default:       if (!alarm_active_q) alarm_en_d = !alarm_en_q;
      endcase
    end

    // Setting the hour restarts the current minute from a clean second boundary.
    if (mode_q == EDIT_HOUR && mode_d != EDIT_HOUR) begin
      sec_d = 8'h00;
      div_d = '0;
    end

    if (alarm_active_q && tick_w) begin
      if (ring_q == RING_LAST) begin
        alarm_active_d = 1'b0;
        ring_d         = 8'd0;
      end else begin
        ring_d = ring_q + 8'd1;
      end
    end

    alarm_hit = tick_w && alarm_en_q && (sec_d == 8'h00) &&
                (min_d == amin_d) && (hour_d == ahour_d);
    if (alarm_hit && !alarm_active_q) begin
      alarm_active_d = 1'b1;
      ring_d         = 8'd0;
    end

    if ((mode_q == RUN && alarm_active_q && (short_press || long_press)) ||
        !alarm_en_d || (mode_q == RUN && mode_d != RUN)) begin
      alarm_active_d = 1'b0;
      ring_d         = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q          <= '0;
      hour_q         <= 8'h00;
      min_q          <= 8'h00;
      sec_q          <= 8'h00;
      ahour_q        <= 8'h00;
      amin_q         <= 8'h00;
      alarm_en_q     <= 1'b0;
      alarm_active_q <= 1'b0;
      ring_q         <= 8'd0;
    end else begin
      div_q          <= div_d;
      hour_q         <= hour_d;
      min_q          <= min_d;
      sec_q          <= sec_d;
      ahour_q        <= ahour_d;
      amin_q         <= amin_d;
      alarm_en_q     <= alarm_en_d;
      alarm_active_q <= alarm_active_d;
      ring_q         <= ring_d;
    end
  end

endmodule

// File: tb/tb_rtc_alarm_core.sv
// Directed bench for rtc_alarm_core with CLK_HZ=4 and ALARM_SEC=3: edits, rollover,
// alarm ring/dismiss and asynchronous reset, each step checked against hand values.
module tb_rtc_alarm_core;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] buttonState = 2'd0;
  logic [3:0] h1, h0, m1, m0, s1, s0, ah1, ah0, am1, am0;
  logic [2:0] mode;
  logic       alarm_en, alarm_active, tick;
  logic [23:0] now_t;
  logic [15:0] alarm_t;

  int n_checks = 0;
  int n_fail   = 0;

  rtc_alarm_core #(.CLK_HZ(4), .ALARM_SEC(3)) dut (
    .clk(clk), .reset(reset), .buttonState(buttonState),
    .h1(h1), .h0(h0), .m1(m1), .m0(m0), .s1(s1), .s0(s0),
    .ah1(ah1), .ah0(ah0), .am1(am1), .am0(am0),
    .mode(mode), .alarm_en(alarm_en), .alarm_active(alarm_active), .tick(tick)
  );

  always #5 clk = ~clk;

  assign now_t   = {h1, h0, m1, m0, s1, s0};
  assign alarm_t = {ah1, ah0, am1, am0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the button is seen by exactly one rising edge.
  task automatic press(input logic [1:0] b);
    buttonState = b;
    @(negedge clk);
    buttonState = 2'd0;
  endtask

  task automatic presses(input logic [1:0] b, input int n);
    for (int i = 0; i < n; i++) press(b);
  endtask

  task automatic wait_tick();
    int k;
    k = 0;
    while (tick !== 1'b1 && k < 16) begin
      @(negedge clk);
      k++;
    end
    chk("tick_seen", 32'(tick), 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_ring(input logic [23:0] exp_t);
    int n;
    n = 0;
    while (alarm_active !== 1'b1 && n < 70) begin
      wait_tick();
      n++;
    end
    chk("ring_start", 32'(alarm_active), 32'd1);
    chk("ring_time", 32'(now_t), 32'(exp_t));
  endtask

  task automatic arm_alarm(input logic [7:0] mins);
    presses(2'd2, 3);
    press(2'd1);
    presses(2'd2, 2);
    chk("arm_mode", 32'(mode), 32'd0);
    chk("arm_alarm", 32'(alarm_t), 32'({8'h00, mins}));
  endtask

  initial begin
    int k;
    int seen;

    // Reset asserted from time zero, before any clock edge.
    #1;
    chk("rst_time", 32'(now_t), 32'h0);
    chk("rst_alarm", 32'(alarm_t), 32'h0);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_en", 32'(alarm_en), 32'd0);
    chk("rst_active", 32'(alarm_active), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Edit cycle: hours to 05, time frozen while editing.
    press(2'd2);
    chk("edit_mode1", 32'(mode), 32'd1);
    press(2'd2);
    chk("edit_mode2", 32'(mode), 32'd2);
    presses(2'd1, 5);
    chk("edit_hour05", 32'(now_t), 32'h050000);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (tick === 1'b1) seen++;
    end
    chk("frozen_tick", 32'(seen), 32'd0);
    chk("frozen_time", 32'(now_t), 32'h050000);
    presses(2'd2, 3);
    chk("edit_back_run", 32'(mode), 32'd0);
    chk("edit_result", 32'(now_t), 32'h050000);

    // Preload 23:59, run to 23:59:59, then roll over.
    press(2'd2);
    presses(2'd1, 59);
    chk("min59", 32'(now_t), 32'h055900);
    press(2'd2);
    presses(2'd1, 18);
    chk("hour23", 32'(now_t), 32'h235900);
    presses(2'd2, 3);
    chk("preload_mode", 32'(mode), 32'd0);
    chk("preload_time", 32'(now_t), 32'h235900);
    repeat (59) wait_tick();
    chk("time_235959", 32'(now_t), 32'h235959);
    k = 0;
    while (tick !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("tick_period", 32'(k), 32'd3);
    @(negedge clk);
    chk("rollover", 32'(now_t), 32'h000000);

    // Alarm minute wrap, enable, ignored button code.
    presses(2'd2, 3);
    chk("alm_min_mode", 32'(mode), 32'd3);
    presses(2'd1, 59);
    chk("alm_min59", 32'(alarm_t), 32'h0059);
    press(2'd1);
    chk("alm_min_wrap", 32'(alarm_t), 32'h0000);
    press(2'd1);
    chk("alm_min01", 32'(alarm_t), 32'h0001);
    presses(2'd2, 2);
    chk("alm_run", 32'(mode), 32'd0);
    press(2'd1);
    chk("alm_enable", 32'(alarm_en), 32'd1);
    press(2'd3);
    chk("btn3_en", 32'(alarm_en), 32'd1);
    chk("btn3_mode", 32'(mode), 32'd0);
    chk("btn3_alarm", 32'(alarm_t), 32'h0001);
    chk("btn3_active", 32'(alarm_active), 32'd0);

    // Ring at 00:01:00 and self-expire after three further ticks.
    wait_ring(24'h000100);
    wait_tick();
    chk("ring_after1", 32'(alarm_active), 32'd1);
    wait_tick();
    chk("ring_after2", 32'(alarm_active), 32'd1);
    wait_tick();
    chk("ring_after3", 32'(alarm_active), 32'd0);
    chk("ring_en_kept", 32'(alarm_en), 32'd1);

    // Dismiss with a short press.
    arm_alarm(8'h02);
    wait_ring(24'h000200);
    press(2'd1);
    chk("dismiss_active", 32'(alarm_active), 32'd0);
    chk("dismiss_en", 32'(alarm_en), 32'd1);
    chk("dismiss_mode", 32'(mode), 32'd0);

    // Dismiss with a long press: mode must not advance.
    arm_alarm(8'h03);
    wait_ring(24'h000300);
    press(2'd2);
    chk("long_dismiss_active", 32'(alarm_active), 32'd0);
    chk("long_dismiss_mode", 32'(mode), 32'd0);

    // Asynchronous reset between clock edges while ringing.
    arm_alarm(8'h04);
    wait_ring(24'h000400);
    #2 reset = 1'b0;
    #1;
    chk("async_time", 32'(now_t), 32'h0);
    chk("async_alarm", 32'(alarm_t), 32'h0);
    chk("async_mode", 32'(mode), 32'd0);
    chk("async_en", 32'(alarm_en), 32'd0);
    chk("async_active", 32'(alarm_active), 32'd0);
    chk("async_tick", 32'(tick), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    k = 0;
    while (tick !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("first_tick", 32'(k), 32'd3);

    // Reset during an edit aborts back to RUN.
    @(negedge clk);
    press(2'd2);
    chk("midedit_mode", 32'(mode), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("midedit_abort", 32'(mode), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
